// File: rtl/sparc_ifu_parchk32.sv
// Parity checker with a 1-deep output register, first-error tag log and saturating error counter.
// Define SPARC_IFU_PARCHK_INJ_EN to add the inj_perr_i error-injection input.
module sparc_ifu_parchk32 (
  input  logic        rclk,
  input  logic        reset,
  input  logic        chk_vld_i,
  output logic        chk_rdy_o,
  input  logic [31:0] chk_data_i,
  input  logic        chk_par_i,
  input  logic [7:0]  chk_tag_i,
  output logic        res_vld_o,
  input  logic        res_rdy_i,
  output logic [31:0] res_data_o,
  output logic        res_perr_o,
  output logic        log_vld_o,
  output logic [7:0]  log_tag_o,
  input  logic        log_clr_i,
  output logic [7:0]  err_cnt_o
`ifdef SPARC_IFU_PARCHK_INJ_EN
  ,
  input  logic        inj_perr_i
`endif
);

  logic        r_resVld;
  logic [31:0] r_resData;
  logic        r_resPerr;
  logic        r_logVld;
  logic [7:0]  r_logTag;
  logic [7:0]  r_errCnt;

  logic        w_inj;
  logic        w_accept;
  logic        w_consume;
  logic        w_perr;
  logic        w_logErr;
  logic        w_logVldNext;
  logic [7:0]  w_logTagNext;
  logic [7:0]  w_errCntNext;

`ifdef SPARC_IFU_PARCHK_INJ_EN
  assign w_inj = inj_perr_i;
`else
  assign w_inj = 1'b0;
`endif

  assign chk_rdy_o = ~r_resVld | res_rdy_i;
  assign w_accept  = chk_vld_i & chk_rdy_o;
  assign w_consume = r_resVld & res_rdy_i;
  assign w_perr    = (^chk_data_i) ^ w_inj ^ chk_par_i;
  assign w_logErr  = w_accept & w_perr;

  // Clear is applied before capture so a clear coinciding with an error logs that error.
  always_comb begin
    w_logVldNext = r_logVld;
    w_logTagNext = r_logTag;
    w_errCntNext = r_errCnt;
    if (log_clr_i) begin
      w_logVldNext = 1'b0;
      w_logTagNext = 8'h00;
      w_errCntNext = 8'h00;
    end
    if (w_logErr) begin
      if (!w_logVldNext) begin
        w_logVldNext = 1'b1;
        w_logTagNext = chk_tag_i;
      end
      if (w_errCntNext != 8'hFF) begin
        w_errCntNext = w_errCntNext + 8'h01;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_resVld  <= 1'b0;
      r_resData <= 32'h0;
      r_resPerr <= 1'b0;
    end else if (w_accept) begin
      r_resVld  <= 1'b1;
      r_resData <= chk_data_i;
      r_resPerr <= w_perr;
    end else if (w_consume) begin
      r_resVld  <= 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_logVld <= 1'b0;
      r_logTag <= 8'h00;
      r_errCnt <= 8'h00;
    end else begin
      r_logVld <= w_logVldNext;
      r_logTag <= w_logTagNext;
      r_errCnt <= w_errCntNext;
    end
  end

  assign res_vld_o  = r_resVld;
  assign res_data_o = r_resData;
  assign res_perr_o = r_resPerr;
  assign log_vld_o  = r_logVld;
  assign log_tag_o  = r_logTag;
  assign err_cnt_o  = r_errCnt;

endmodule

// File: doc/sparc_ifu_parchk32.md
SPARC_IFU_PARCHK32 -- requirements
Module: sparc_ifu_parchk32

Interface
REQ-001 The block SHALL have exactly one clock and use a synchronous, active-high reset: `rclk` input 1, clock; all state updates on the rising edge.
REQ-002 `reset` input 1: synchronous, active-high reset.
REQ-003 `chk_vld_i` input 1: an input word is offered.
REQ-004 `chk_rdy_o` output 1: the block can accept an input word this cycle.
REQ-005 `chk_data_i` input 32: the protected data word.
REQ-006 `chk_par_i` input 1: the stored parity bit; it is 1 when `chk_data_i` holds an odd number of ones.
REQ-007 `chk_tag_i` input 8: the source index or tag for the word.
REQ-008 `res_vld_o` output 1: a checked result is held.
REQ-009 `res_rdy_i` input 1: the consumer accepts the result.
REQ-010 `res_data_o` output 32: the registered data word.
REQ-011 `res_perr_o` output 1: the registered parity-error flag for `res_data_o`.
REQ-012 `log_vld_o` output 1: sticky flag; the error log holds a captured error.
REQ-013 `log_tag_o` output 8: the tag of the first error captured since the last clear.
REQ-014 `log_clr_i` input 1: clears the error log and the error counter.
REQ-015 `err_cnt_o` output 8: saturating count of accepted words that had a parity error.

Function
REQ-016 The input handshake SHALL complete (accept) when `chk_vld_i` and `chk_rdy_o` are both 1.
REQ-017 The output handshake SHALL complete (consume) when `res_vld_o` and `res_rdy_i` are both 1.
REQ-018 The computed parity SHALL be the XOR reduction of all 32 bits of `chk_data_i`.
REQ-019 A parity error SHALL be flagged when the computed parity differs from `chk_par_i`.
REQ-020 `chk_rdy_o` SHALL equal (!res_vld_o | res_rdy_i), and SHALL be purely combinational from the state and `res_rdy_i`.
REQ-021 On accept, the data word and its error flag SHALL be registered into the output stage and presented with `res_vld_o`=1 on the next cycle (1-cycle latency).
REQ-022 Back-to-back accepts SHALL be supported with zero bubbles while `res_rdy_i`=1.
REQ-023 On consume with no accept in the same cycle, `res_vld_o` SHALL go to 0 on the next edge.
REQ-024 On consume with an accept in the same cycle, the output stage SHALL be reloaded with the new word and `res_vld_o` SHALL stay 1.
REQ-025 While `res_vld_o`=1 and `res_rdy_i`=0, `res_data_o` and `res_perr_o` SHALL hold stable.
REQ-026 Logging SHALL occur at accept time, not at output time.
REQ-027 If an accepted word has an error and `log_vld_o`=0, `log_tag_o` SHALL capture `chk_tag_i` and `log_vld_o` SHALL be set on the next edge.
REQ-028 If an accepted word has an error and `log_vld_o`=1, the log SHALL be left unchanged (first error wins).
REQ-029 `err_cnt_o` SHALL increment by 1 for each accepted word with an error and SHALL saturate at 255 without wrapping.
REQ-030 `log_clr_i`=1 SHALL clear `log_vld_o`, `log_tag_o` and `err_cnt_o` on the next edge.
REQ-031 When `log_clr_i`=1 coincides with an accepted erroneous word, the clear SHALL apply first and then the capture: `log_vld_o`=1, `log_tag_o`=that word's tag, `err_cnt_o`=1.

Reset
REQ-032 While `reset`=1 at a clock edge, `res_vld_o`, `res_perr_o`, `log_vld_o`, `log_tag_o`, `err_cnt_o` and `res_data_o` SHALL all go to 0, overriding any handshake or clear.
REQ-033 During reset `chk_rdy_o` SHALL evaluate to 1, but an accept in a reset cycle SHALL be discarded.
REQ-034 A word held in the output stage when reset is asserted mid-stream SHALL be dropped.

Configuration
REQ-035 The macro SPARC_IFU_PARCHK_INJ_EN SHALL control error injection.
REQ-036 When SPARC_IFU_PARCHK_INJ_EN is defined, the block SHALL have an extra input `inj_perr_i` (1 bit); when it is 1 during an accept, the computed parity SHALL be inverted, forcing an error flag and the logging/counting effects on a clean word.
REQ-037 When SPARC_IFU_PARCHK_INJ_EN is not defined, the port SHALL be absent and the behaviour SHALL equal the defined case with `inj_perr_i`=0.

Verification
REQ-038 Clean word: data 0x0000_0003, par 0, tag 0x11, `res_rdy_i`=1 -> next cycle `res_vld_o`=1, `res_data_o`=0x0000_0003, `res_perr_o`=0, `err_cnt_o`=0, `log_vld_o`=0.
REQ-039 Errors: data 0x8000_0000 with par 0 and tag 0x2A, then data 0x0000_0001 with par 0 and tag 0x3B, back-to-back -> `res_perr_o`=1 on both, `log_tag_o`=0x2A, `err_cnt_o`=2, no bubbles.
REQ-040 Backpressure: `res_rdy_i`=0 for 3 cycles with `chk_vld_i`=1 -> `chk_rdy_o`=0 after the first accept, output held stable; release -> the second word is presented the next cycle with none lost or duplicated.
REQ-041 Saturation and clear: 260 erroneous words -> `err_cnt_o`=255; `log_clr_i` pulsed alongside an erroneous word with tag 0x7F -> `err_cnt_o`=1, `log_tag_o`=0x7F, `log_vld_o`=1.
REQ-042 Reset mid-stream: `reset` asserted while `res_vld_o`=1 and `err_cnt_o`=5 -> next cycle all outputs are 0 and `chk_rdy_o`=1.
REQ-043 With SPARC_IFU_PARCHK_INJ_EN defined: `inj_perr_i`=1 with data 0x0 and par 0 -> `res_perr_o`=1 and `err_cnt_o`=1.
